// File: rtl/gfm_pkg.sv
// Shared types and constants for the GF(2) MAC column sequencer.
// Select codes are the mode encodings understood by every cell in the column.
package gfm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_DONE
  } gfm_seq_state_t;

  localparam logic [1:0] GFM_SEL_HOLD = 2'b00;
  localparam logic [1:0] GFM_SEL_MAC  = 2'b10;
  localparam logic [1:0] GFM_SEL_LOAD = 2'b11;

  localparam int GFM_CNT_W = 8;

endpackage

// File: rtl/gfm_beat_cnt.sv
// Saturating 8-bit beat counter with a terminal flag that fires on the beat
// that completes `limit` beats, so a phase can exit on that same edge.
module gfm_beat_cnt
  import gfm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [GFM_CNT_W-1:0] limit,
  output logic                 term
);

  logic [GFM_CNT_W-1:0] cnt;
  logic [GFM_CNT_W:0]   cnt_inc;

  // One extra bit keeps the compare exact when limit is 255.
  assign cnt_inc = {1'b0, cnt} + {{GFM_CNT_W{1'b0}}, 1'b1};
  assign term    = inc & (cnt_inc == {1'b0, limit});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {GFM_CNT_W{1'b1}})) begin
      cnt <= cnt_inc[GFM_CNT_W-1:0];
    end
  end

endmodule

// File: rtl/gfm_seq_ctrl.sv
// Job sequencer for a column of GF(2) multiply-accumulate cells: LOAD, MAC, DRAIN.
// state | meaning
// IDLE  | waiting for start; array held
// LOAD  | shift ROWS operand words in from the top
// MAC   | XOR-accumulate cfg_k side words into every cell
// DRAIN | shift ROWS results out of the bottom cell, zeros in at the top
// DONE  | one-cycle completion pulse
module gfm_seq_ctrl
  import gfm_pkg::*;
#(
  parameter int N    = 32,
  parameter int ROWS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   cfg_k,
  output logic         busy,
  output logic         done,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [N-1:0] ld_data,
  input  logic         sd_valid,
  output logic         sd_ready,
  input  logic [N-1:0] sd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N-1:0] rd_data,
  output logic         arr_en,
  output logic [1:0]   arr_sel,
  output logic [N-1:0] arr_top,
  output logic [N-1:0] arr_side,
  input  logic [N-1:0] arr_bottom
);

  localparam logic [GFM_CNT_W-1:0] ROWS_LIM = ROWS[GFM_CNT_W-1:0];

  gfm_seq_state_t       state, state_nxt;
  logic [GFM_CNT_W-1:0] k_lim;
  logic                 ld_beat, sd_beat, rd_beat;
  logic                 row_clr, row_term, k_clr, k_term;
  logic                 accept;

  assign accept  = (state == ST_IDLE) & start & ~abort;
  assign ld_beat = ld_valid & ld_ready;
  assign sd_beat = sd_valid & sd_ready;
  assign rd_beat = rd_valid & rd_ready;

  // The row counter is shared by LOAD and DRAIN; clearing on its own terminal
  // beat lets LOAD hand over straight to DRAIN when cfg_k is zero.
  assign row_clr = abort | row_term | (state == ST_IDLE) | (state == ST_MAC) | (state == ST_DONE);
  assign k_clr   = abort | k_term | (state != ST_MAC);

  gfm_beat_cnt u_row_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (row_clr),
    .inc     (ld_beat | rd_beat),
    .limit   (ROWS_LIM),
    .term    (row_term)
  );

  gfm_beat_cnt u_k_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (k_clr),
    .inc     (sd_beat),
    .limit   (k_lim),
    .term    (k_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      k_lim <= '0;
    end else begin
      state <= state_nxt;
      if (accept) k_lim <= cfg_k;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (accept) state_nxt = ST_LOAD;
        ST_LOAD:  if (row_term) state_nxt = (k_lim == '0) ? ST_DRAIN : ST_MAC;
        ST_MAC:   if (k_term) state_nxt = ST_DRAIN;
        ST_DRAIN: if (row_term) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort silences every handshake in its cycle so no beat is half-accepted.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ld_ready = 1'b0;
    sd_ready = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    arr_en   = 1'b0;
    arr_sel  = GFM_SEL_HOLD;
    arr_top  = '0;
    arr_side = '0;
    unique case (state)
      ST_LOAD: begin
        busy = 1'b1;
        if (!abort) begin
          ld_ready = 1'b1;
          arr_top  = ld_data;
          arr_en   = ld_valid;
        end
      end
      ST_MAC: begin
        busy = 1'b1;
        if (!abort) begin
          sd_ready = 1'b1;
          arr_side = sd_data;
          arr_en   = sd_valid;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!abort) begin
          rd_valid = 1'b1;
          rd_data  = arr_bottom;
          arr_en   = rd_ready;
        end
      end
      ST_DONE: done = ~abort;
      default: ;
    endcase
    if (arr_en) arr_sel = (state == ST_MAC) ? GFM_SEL_MAC : GFM_SEL_LOAD;
  end

endmodule

// File: tb/tb_gfm_seq_ctrl.sv
// Bench for gfm_seq_ctrl: a behavioural cell column supplies arr_bottom, and
// results are predicted as loaded word XOR the fold of all side words.
module tb_gfm_seq_ctrl;

  localparam int N    = 8;
  localparam int ROWS = 4;

  typedef logic [N-1:0] wvec_t [ROWS];
  typedef logic [N-1:0] svec_t [8];
  typedef logic [N-1:0] wq_t [$];

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic [7:0]   cfg_k = '0;
  logic         busy, done;
  logic         ld_valid = 1'b0, ld_ready;
  logic [N-1:0] ld_data = '0;
  logic         sd_valid = 1'b0, sd_ready;
  logic [N-1:0] sd_data = '0;
  logic         rd_valid, rd_ready = 1'b0;
  logic [N-1:0] rd_data;
  logic         arr_en;
  logic [1:0]   arr_sel;
  logic [N-1:0] arr_top, arr_side, arr_bottom;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gfm_seq_ctrl #(.N(N), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cfg_k(cfg_k),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .sd_valid(sd_valid), .sd_ready(sd_ready), .sd_data(sd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .arr_en(arr_en), .arr_sel(arr_sel), .arr_top(arr_top), .arr_side(arr_side),
    .arr_bottom(arr_bottom)
  );

  // Behavioural cell column, driven by values captured mid-cycle.
  logic [N-1:0] col [ROWS];
  logic         cap_en = 1'b0;
  logic [1:0]   cap_sel = '0;
  logic [N-1:0] cap_top = '0, cap_side = '0;

  assign arr_bottom = col[ROWS-1];

  always @(negedge clk) begin
    #2;
    cap_en   <= arr_en;
    cap_sel  <= arr_sel;
    cap_top  <= arr_top;
    cap_side <= arr_side;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) col[i] <= '0;
    end else if (cap_en && cap_sel == 2'b11) begin
      col[0] <= cap_top;
      for (int i = 1; i < ROWS; i++) col[i] <= col[i-1];
    end else if (cap_en && cap_sel == 2'b10) begin
      for (int i = 0; i < ROWS; i++) col[i] <= col[i] ^ cap_side;
    end
  end

  function automatic logic [N-1:0] side_fold(input svec_t s, input int k);
    logic [N-1:0] f = '0;
    for (int i = 0; i < k; i++) f ^= s[i];
    return f;
  endfunction

  // mode 0: no stalls; 1: ld_valid/rd_ready toggle each cycle; 2: random.
  task automatic run_job(input wvec_t words, input svec_t sides, input int k,
                         input int mode, input bit hold_start,
                         output wq_t res, output int done_cyc,
                         output int proto_bad, output int sd_seen);
    int li = 0, si = 0;
    bit pat, exp_en;
    logic [1:0] exp_sel;
    res = {};
    done_cyc = -1;
    proto_bad = 0;
    sd_seen = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; cfg_k = k[7:0];
    ld_valid = 1'b0; sd_valid = 1'b0; rd_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      case (mode)
        0: pat = 1'b1;
        1: pat = c[0];
        default: pat = 1'($urandom_range(0, 1));
      endcase
      ld_valid = pat && (li < ROWS);
      ld_data  = words[(li < ROWS) ? li : 0];
      sd_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      sd_data  = sides[(si < 8) ? si : 0];
      rd_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : pat;
      #1;
      if (sd_ready) sd_seen++;
      exp_en  = (ld_valid && ld_ready) || (sd_valid && sd_ready) || (rd_valid && rd_ready);
      exp_sel = !exp_en ? 2'b00 : (sd_valid && sd_ready) ? 2'b10 : 2'b11;
      if (arr_en !== exp_en) proto_bad++;
      if (arr_sel !== exp_sel) proto_bad++;
      if (busy !== !done) proto_bad++;
      if (ld_valid && ld_ready) li++;
      if (sd_valid && sd_ready) si++;
      if (rd_valid && rd_ready) res.push_back(rd_data);
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    ld_valid = 1'b0; sd_valid = 1'b0; rd_ready = 1'b0;
  endtask

  // Free-running stream with every handshake asserted; no sampling.
  task automatic pump(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 1'b0;
      ld_valid = 1'b1; ld_data = N'($urandom);
      sd_valid = 1'b1; sd_data = N'($urandom);
      rd_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, ld_ready, sd_ready, rd_valid, arr_en, arr_sel, arr_top, arr_side, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b sel=%b top=%h side=%h", busy, done, arr_en, arr_sel, arr_top, arr_side);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, ld_ready, arr_en, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ld_ready=%b arr_en=%b done=%b expected all 0", busy, ld_ready, arr_en, done);
    end
  endtask

  task automatic test_job(input string name, input wvec_t w, input svec_t s, input int k,
                          input int mode, input bit check_lat);
    wq_t res;
    int dc, pb, sdn;
    logic [N-1:0] fold;
    run_job(w, s, k, mode, 1'b0, res, dc, pb, sdn);
    fold = side_fold(s, k);
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL %s_timeout: done not seen, required done within 300 cycles", name);
    end
    checks++;
    if (res.size() !== ROWS) begin
      errors++;
      $display("FAIL %s_count: got %0d results, required %0d", name, res.size(), ROWS);
    end
    for (int i = 0; i < ROWS && i < res.size(); i++) begin
      checks++;
      if (res[i] !== (w[i] ^ fold)) begin
        errors++;
        $display("FAIL %s_word%0d: got %h required %h", name, i, res[i], w[i] ^ fold);
      end
    end
    checks++;
    if (pb !== 0) begin
      errors++;
      $display("FAIL %s_protocol: got %0d arr_en/arr_sel/busy violations, required 0", name, pb);
    end
    if (check_lat) begin
      // Cycle count includes the cycle in which start is sampled.
      checks++;
      if (dc + 1 !== 2 + 2 * ROWS + k) begin
        errors++;
        $display("FAIL %s_latency: done at cycle %0d required %0d", name, dc + 1, 2 + 2 * ROWS + k);
      end
      checks++;
      if (sdn !== k) begin
        errors++;
        $display("FAIL %s_sd_ready: got %0d cycles required %0d", name, sdn, k);
      end
    end
  endtask

  task automatic test_basic();
    wvec_t w = '{8'h01, 8'h02, 8'h04, 8'h08};
    svec_t s = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    test_job("basic", w, s, 2, 0, 1'b1);
  endtask

  task automatic test_stall();
    wvec_t w = '{8'h01, 8'h02, 8'h04, 8'h08};
    svec_t s = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    test_job("stall", w, s, 2, 1, 1'b0);
  endtask

  task automatic test_k0();
    wvec_t w = '{8'h5A, 8'hC3, 8'h81, 8'h7E};
    svec_t s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    test_job("k0", w, s, 0, 0, 1'b1);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1; cfg_k = 8'd3;
    pump(ROWS + 1);
    @(negedge clk);
    abort = 1'b1; sd_valid = 1'b1; rd_ready = 1'b1;
    #1;
    checks++;
    if ({arr_en, sd_ready, done} !== 3'b0) begin
      errors++;
      $display("FAIL abort_cycle: arr_en=%b sd_ready=%b done=%b required 0", arr_en, sd_ready, done);
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b required 0", busy, done);
    end
    start = 1'b1; cfg_k = 8'd1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if ({busy, ld_ready} !== 2'b11) begin
      errors++;
      $display("FAIL abort_restart: busy=%b ld_ready=%b required 1", busy, ld_ready);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    start = 1'b1; cfg_k = 8'd1;
    pump(ROWS + 1 + 2);
    @(negedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_drain_pre: rd_valid=%b required 1", rd_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ld_ready, sd_ready, rd_valid, arr_en, arr_sel, arr_top, arr_side, rd_data} !== '0) begin
      errors++;
      $display("FAIL rst_drain_outputs: busy=%b rd_valid=%b en=%b sel=%b top=%h side=%h rd=%h required 0",
               busy, rd_valid, arr_en, arr_sel, arr_top, arr_side, rd_data);
    end
    ld_valid = 1'b0; sd_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, ld_ready, rd_valid} !== 3'b0) begin
      errors++;
      $display("FAIL rst_drain_idle: busy=%b ld_ready=%b rd_valid=%b required 0", busy, ld_ready, rd_valid);
    end
  endtask

  task automatic test_start_held();
    wvec_t w = '{8'h11, 8'h22, 8'h44, 8'h88};
    svec_t s = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    wq_t res;
    int dc, pb, sdn;
    run_job(w, s, 1, 0, 1'b1, res, dc, pb, sdn);
    checks++;
    if (dc + 1 !== 2 + 2 * ROWS + 1 || res.size() !== ROWS) begin
      errors++;
      $display("FAIL held_job: done cycle %0d results %0d, required %0d and %0d", dc + 1, res.size(), 2 + 2 * ROWS + 1, ROWS);
    end
    checks++;
    if (res.size() == ROWS && res[ROWS-1] !== (w[ROWS-1] ^ 8'h3C)) begin
      errors++;
      $display("FAIL held_last_word: got %h required %h", res[ROWS-1], w[ROWS-1] ^ 8'h3C);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, ld_ready} !== 2'b00) begin
      errors++;
      $display("FAIL held_idle_gap: busy=%b ld_ready=%b required 0", busy, ld_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, ld_ready} !== 2'b11) begin
      errors++;
      $display("FAIL held_second_job: busy=%b ld_ready=%b required 1", busy, ld_ready);
    end
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_random();
    wvec_t w;
    svec_t s;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < ROWS; i++) w[i] = N'($urandom);
      for (int i = 0; i < 8; i++) s[i] = N'($urandom);
      test_job($sformatf("rand%0d", j), w, s, $urandom_range(0, 5), 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_k0();
    test_abort();
    test_job("post_abort", '{8'hA1, 8'hB2, 8'hC3, 8'hD4},
             '{8'h0F, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 1'b1);
    test_reset_mid_drain();
    test_job("post_reset", '{8'h10, 8'h20, 8'h30, 8'h40},
             '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 1'b1);
    test_start_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
